// File: rtl/updown_counter_ext_pkg.sv
// Shared types and helpers for the extended up/down counter.
package updown_counter_ext_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } counter_mode_t;

  // Operands are non-negative and narrower than 32 bits, so int arithmetic is exact.
  function automatic int clamp_val(input int val, input int lo, input int hi);
    int res;
    if (val < lo) begin
      res = lo;
    end else if (val > hi) begin
      res = hi;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/updown_counter_ext_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface updown_counter_ext_if #(
  parameter int counter_bits = 8
);
  import updown_counter_ext_pkg::*;

  logic                    en;
  logic                    Mas;
  logic                    Menos;
  counter_mode_t           mode;
  logic                    load;
  logic [counter_bits-1:0] load_val;
  logic [counter_bits-1:0] Counting;
  logic                    at_max;
  logic                    at_min;
  logic                    ovf;
  logic                    unf;

  modport master (
    output en, Mas, Menos, mode, load, load_val,
    input  Counting, at_max, at_min, ovf, unf
  );

  modport slave (
    input  en, Mas, Menos, mode, load, load_val,
    output Counting, at_max, at_min, ovf, unf
  );

endinterface

// File: rtl/updown_counter_ext_rise_detect.sv
// Rising-edge detector: the history bit clears on reset, so an input held high
// across reset release reports exactly one edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/updown_counter_ext.sv
// Parametrised up/down counter over [MIN_VAL, MAX_VAL] with step, wrap/saturate,
// load, enable, optional edge qualification and overflow/underflow pulses.
module updown_counter_ext
  import updown_counter_ext_pkg::*;
#(
  parameter int counter_bits = 8,
  parameter int MIN_VAL      = 0,
  parameter int MAX_VAL      = 2**counter_bits - 1,
  parameter int STEP         = 1,
  parameter int EDGE_MODE    = 0
) (
  input logic                clk,
  input logic                rst,
  updown_counter_ext_if.slave bus
);

  // One extra bit keeps count+STEP and the wrap sums free of truncation.
  localparam int WE = counter_bits + 1;
  localparam logic [WE-1:0] MAX_E        = WE'(MAX_VAL);
  localparam logic [WE-1:0] STEP_E       = WE'(STEP);
  localparam logic [WE-1:0] RANGE_E      = WE'(MAX_VAL - MIN_VAL + 1);
  localparam logic [WE-1:0] MIN_STEP_E   = WE'(MIN_VAL + STEP);
  localparam logic [WE-1:0] WRAP_DN_E    = WE'(MAX_VAL - MIN_VAL + 1 - STEP);
  localparam logic [counter_bits-1:0] MIN_C = counter_bits'(MIN_VAL);
  localparam logic [counter_bits-1:0] MAX_C = counter_bits'(MAX_VAL);

  logic [counter_bits-1:0] count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    up_s, dn_s;
  logic [WE-1:0]           count_ext_s;
  logic [WE-1:0]           sum_up_s;
  logic [counter_bits-1:0] load_clamp_s;

  generate
    if (EDGE_MODE == 1) begin : g_edge
      rise_detect u_rise_up (.clk(clk), .rst(rst), .d_i(bus.Mas),   .rise_o(up_s));
      rise_detect u_rise_dn (.clk(clk), .rst(rst), .d_i(bus.Menos), .rise_o(dn_s));
    end else begin : g_level
      assign up_s = bus.Mas;
      assign dn_s = bus.Menos;
    end
  endgenerate

  assign count_ext_s  = {1'b0, count_q};
  assign sum_up_s     = count_ext_s + STEP_E;
  assign load_clamp_s = counter_bits'(clamp_val(int'(bus.load_val), MIN_VAL, MAX_VAL));

  // Next count and pulses, highest priority first: load, enable, conflict, up, down.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (bus.load) begin
      count_d = load_clamp_s;
    end else if (!bus.en) begin
      count_d = count_q;
    end else if (up_s && dn_s) begin
      count_d = count_q;
    end else if (up_s) begin
      if (sum_up_s > MAX_E) begin
        ovf_d = 1'b1;
        if (bus.mode == CNT_SAT) begin
          count_d = MAX_C;
        end else begin
          count_d = counter_bits'(sum_up_s - RANGE_E);
        end
      end else begin
        count_d = counter_bits'(sum_up_s);
      end
    end else if (dn_s) begin
      if (count_ext_s < MIN_STEP_E) begin
        unf_d = 1'b1;
        if (bus.mode == CNT_SAT) begin
          count_d = MIN_C;
        end else begin
          count_d = counter_bits'(count_ext_s + WRAP_DN_E);
        end
      end else begin
        count_d = counter_bits'(count_ext_s - STEP_E);
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= MIN_C;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.Counting = count_q;
  assign bus.at_max   = (count_q == MAX_C);
  assign bus.at_min   = (count_q == MIN_C);
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;

endmodule

// File: doc/updown_counter_ext.md
Name: updown_counter_ext

Overview:
- Parametrised up/down counter that extends the basic Mas/Menos counter.
- Adds a configurable width and range [MIN_VAL, MAX_VAL], a step size, and run-time wrap or saturate mode.
- Adds synchronous load, a count enable, optional rising-edge qualification of the up/down inputs, and boundary flags with overflow/underflow pulses.
- Used for user-adjustable set points and for event tallies on push-button or strobe inputs.

Parameters:
- counter_bits, 8: width of count and load value.
- MIN_VAL, 0: lowest legal count; also the reset value.
- MAX_VAL, 2**counter_bits-1: highest legal count. MIN_VAL < MAX_VAL.
- STEP, 1: increment/decrement magnitude. 1 <= STEP <= MAX_VAL-MIN_VAL+1.
- EDGE_MODE, 0: 0 = Mas/Menos act on level each cycle; 1 = act on rising edge only.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  count enable; low holds count (load still honoured).
- Mas  in  1  count-up request.
- Menos  in  1  count-down request.
- mode  in  1  0 = wrap, 1 = saturate (counter_mode_t).
- load  in  1  synchronous load strobe.
- load_val  in  counter_bits  value to load.
- Counting  out  counter_bits  current count.
- at_max  out  1  Counting == MAX_VAL (combinational from register).
- at_min  out  1  Counting == MIN_VAL (combinational from register).
- ovf  out  1  one-cycle pulse: up step attempted past MAX_VAL.
- unf  out  1  one-cycle pulse: down step attempted past MIN_VAL.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-low, sampled on the rising edge of clk only.
- Reset: Counting=MIN_VAL, ovf=0, unf=0, edge registers=0. at_min=1 and at_max=0 follow from the count.
- Latency: every update is registered. An input sampled at edge N is visible on Counting after edge N. ovf/unf are registered and high for exactly the cycle after the offending edge.
- Effective requests:
  - EDGE_MODE=0: up=Mas, dn=Menos.
  - EDGE_MODE=1: up=Mas & ~Mas_q, dn=Menos & ~Menos_q.
  - Edge registers update every cycle, including when en=0 or load=1.
  - An input held high through reset release yields one step on the first cycle after release.
- Priority per cycle: rst low > load > en low (hold) > (up & dn) hold > up > down > hold.
- Load: Counting <= clamp(load_val, MIN_VAL, MAX_VAL); ovf=unf=0. Load ignores en and mode.
- Arithmetic: use counter_bits+1 internally; no intermediate truncation. R = MAX_VAL-MIN_VAL+1.
- Up step, count+STEP <= MAX_VAL: count += STEP.
- Up step, count+STEP > MAX_VAL:
  - Wrap: count <= count+STEP-R.
  - Saturate: count <= MAX_VAL.
  - ovf=1 in both modes.
- Down step, count-STEP >= MIN_VAL: count -= STEP.
- Down step, count-STEP < MIN_VAL:
  - Wrap: count <= count-STEP+R.
  - Saturate: count <= MIN_VAL.
  - unf=1 in both modes.
- Saturate at the rail: a further request is still flagged (ovf at MAX_VAL, unf at MIN_VAL) while the count holds.
- Simultaneous up & dn: hold count; no ovf/unf.
- mode change takes effect on the next step; no retroactive correction.
- Reset mid-operation overrides load and any pending step in the same cycle.

Decomposition:
- counter_pkg: typedef enum logic {CNT_WRAP=1'b0, CNT_SAT=1'b1} counter_mode_t.
- counter_pkg: function clamp_val for load_val clamping.
- Sub-module rise_detect (1-bit registered rising-edge detector, sync active-low reset to 0): instantiated twice under generate when EDGE_MODE=1.

Test Plan:
1. Defaults, wrap mode: reset, then Mas=1 for 256 cycles -> Counting 1..255 then 0. ovf pulses once, the cycle 0 appears. at_max high exactly while 255.
2. MIN_VAL=2, MAX_VAL=9, STEP=3, wrap: load 8, one up -> 3 (8+3-8) with ovf. One down -> 8 with unf.
3. Saturate mode, defaults: load 254, Mas=1 for 3 cycles -> 255, 255, 255. ovf=0 on the first step, then high on the second and third. Menos at 0 -> stays 0, unf=1.
4. Mas=Menos=1 at count 5 -> holds 5, no pulses. en=0 with Mas=1 -> holds. load=1, load_val=300 (counter_bits=9, MAX_VAL=200) -> 200.
5. EDGE_MODE=1: Mas held high 10 cycles -> exactly one increment. Mas toggled 4 times -> +4. Mas high through reset release -> one step after release.
6. rst low asserted mid-count (count=77) together with load=1 -> Counting=MIN_VAL next cycle, ovf=unf=0. An async glitch on rst between edges -> no effect.
